// File: rtl/vga_pkg.sv
// Shared VGA constants and types for the timing generator and the screen renderers.
// All counts are in pixels (horizontal) or lines (vertical); sync-end values are inclusive.
package vga_pkg;

   localparam int VGA_H_DISPLAY    = 640;
   localparam int VGA_H_FP         = 16;
   localparam int VGA_H_SYNC       = 96;
   localparam int VGA_H_BP         = 48;
   localparam int VGA_H_TOTAL      = VGA_H_DISPLAY + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_H_SYNC_START = VGA_H_DISPLAY + VGA_H_FP;
   localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;

   localparam int VGA_V_DISPLAY    = 480;
   localparam int VGA_V_FP         = 10;
   localparam int VGA_V_SYNC       = 2;
   localparam int VGA_V_BP         = 33;
   localparam int VGA_V_TOTAL      = VGA_V_DISPLAY + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
   localparam int VGA_V_SYNC_START = VGA_V_DISPLAY + VGA_V_FP;
   localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

   localparam int VGA_COLOR_W = 5;
   localparam int VGA_CNT_W   = 11;
   localparam int VGA_FRAME_W = 28;

   typedef logic [VGA_CNT_W-1:0]   vga_count_t;
   typedef logic [VGA_COLOR_W-1:0] vga_color_t;

   typedef struct packed {
      vga_color_t r;
      vga_color_t g;
      vga_color_t b;
   } vga_rgb_t;

   // Inclusive unsigned range test on full-width counts.
   function automatic logic inWindow(input vga_count_t value, input vga_count_t lo, input vga_count_t hi);
      return (value >= lo) && (value <= hi);
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bus: the generator drives the master side, renderers sit on the slave side.
interface vga_timing_gen_if;
   import vga_pkg::*;

   logic                   enable;
   logic                   pixel_tick;
   logic                   hsync;
   logic                   vsync;
   logic                   video_on;
   vga_count_t             pixel_x;
   vga_count_t             pixel_y;
   logic [VGA_FRAME_W-1:0] frame_count;
   logic                   frame_start;

   modport master (
      input  enable,
      output pixel_tick, hsync, vsync, video_on, pixel_x, pixel_y, frame_count, frame_start
   );

   modport slave (
      output enable,
      input  pixel_tick, hsync, vsync, video_on, pixel_x, pixel_y, frame_count, frame_start
   );

endinterface

// File: rtl/mod_n_counter.sv
// Modulo-N counter with enable; exposes the next value so callers can register decodes in step.
module mod_n_counter #(
   parameter int WIDTH   = 11,
   parameter int MODULUS = 800
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_enable,
   output logic [WIDTH-1:0] o_count,
   output logic [WIDTH-1:0] o_next,
   output logic             o_carry
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_next;
   logic             w_carry;

   always_comb begin
      w_carry = i_enable && (r_count == LAST);
      w_next  = r_count;
      if (w_carry) begin
         w_next = '0;
      end else if (i_enable) begin
         w_next = r_count + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else begin
         r_count <= w_next;
      end
   end

   assign o_count = r_count;
   assign o_next  = w_next;
   assign o_carry = w_carry;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: clock divider plus chained horizontal/vertical counters, with sync,
// blanking and frame markers registered from the next count so they never lag the counts.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV   = 4,
   parameter int H_DISPLAY = VGA_H_DISPLAY,
   parameter int H_FP      = VGA_H_FP,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BP      = VGA_H_BP,
   parameter int V_DISPLAY = VGA_V_DISPLAY,
   parameter int V_FP      = VGA_V_FP,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BP      = VGA_V_BP
) (
   input  logic             clk,
   input  logic             reset_n,
   vga_timing_gen_if.master vga
);

   localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = $clog2(CLK_DIV);

   localparam vga_count_t X_VISIBLE = VGA_CNT_W'(H_DISPLAY);
   localparam vga_count_t Y_VISIBLE = VGA_CNT_W'(V_DISPLAY);
   localparam vga_count_t HS_FIRST  = VGA_CNT_W'(H_DISPLAY + H_FP);
   localparam vga_count_t HS_LAST   = VGA_CNT_W'(H_DISPLAY + H_FP + H_SYNC - 1);
   localparam vga_count_t VS_FIRST  = VGA_CNT_W'(V_DISPLAY + V_FP);
   localparam vga_count_t VS_LAST   = VGA_CNT_W'(V_DISPLAY + V_FP + V_SYNC - 1);

   logic [DIV_W-1:0]       w_div_unused_count;
   logic [DIV_W-1:0]       w_div_unused_next;
   logic                   w_tick;
   logic                   w_h_carry;
   logic                   w_v_carry;
   vga_count_t             w_x;
   vga_count_t             w_x_next;
   vga_count_t             w_y;
   vga_count_t             w_y_next;
   logic [VGA_FRAME_W-1:0] w_frame_count_next;

   logic                   r_hsync;
   logic                   r_vsync;
   logic                   r_video_on;
   logic                   r_frame_start;
   logic [VGA_FRAME_W-1:0] r_frame_count;

   // The divider carry is the pixel strobe; it drops at once when enable goes low.
   mod_n_counter #(.WIDTH(DIV_W), .MODULUS(CLK_DIV)) u_div (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_enable (vga.enable),
      .o_count  (w_div_unused_count),
      .o_next   (w_div_unused_next),
      .o_carry  (w_tick)
   );

   mod_n_counter #(.WIDTH(VGA_CNT_W), .MODULUS(H_TOTAL)) u_hcnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_enable (w_tick),
      .o_count  (w_x),
      .o_next   (w_x_next),
      .o_carry  (w_h_carry)
   );

   mod_n_counter #(.WIDTH(VGA_CNT_W), .MODULUS(V_TOTAL)) u_vcnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_enable (w_h_carry),
      .o_count  (w_y),
      .o_next   (w_y_next),
      .o_carry  (w_v_carry)
   );

   // Frame counter is rewritten every clock so its value always comes from the register path.
   assign w_frame_count_next = w_v_carry ? (r_frame_count + VGA_FRAME_W'(1)) : r_frame_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hsync       <= 1'b1;
         r_vsync       <= 1'b1;
         r_video_on    <= 1'b1;
         r_frame_start <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_hsync       <= !inWindow(w_x_next, HS_FIRST, HS_LAST);
         r_vsync       <= !inWindow(w_y_next, VS_FIRST, VS_LAST);
         r_video_on    <= (w_x_next < X_VISIBLE) && (w_y_next < Y_VISIBLE);
         r_frame_start <= w_v_carry;
         r_frame_count <= w_frame_count_next;
      end
   end

   assign vga.pixel_tick  = w_tick;
   assign vga.hsync       = r_hsync;
   assign vga.vsync       = r_vsync;
   assign vga.video_on    = r_video_on;
   assign vga.pixel_x     = w_x;
   assign vga.pixel_y     = w_y;
   assign vga.frame_count = r_frame_count;
   assign vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a full-size 640x480 instance for tick/line/enable/reset behaviour and a
// shrunken instance (15x12 raster, 2 clocks per pixel) for whole-frame and frame-counter wrap.
module tb_vga_timing_gen;
   import vga_pkg::*;

   logic clk = 1'b0;
   logic rstA;
   logic rstB;

   int checkCount = 0;
   int errorCount = 0;

   int px, py, bad, ticks, vsLowTicks, hsLowTicks, starts, firstHsX, firstBlankX, waitCount;
   logic hsSnap, vsSnap, voSnap;
   logic [VGA_FRAME_W-1:0] fcSnap;

   vga_timing_gen_if vgaA();
   vga_timing_gen_if vgaB();

   vga_timing_gen dutA (
      .clk     (clk),
      .reset_n (rstA),
      .vga     (vgaA)
   );

   vga_timing_gen #(
      .CLK_DIV(2), .H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_DISPLAY(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
   ) dutB (
      .clk     (clk),
      .reset_n (rstB),
      .vga     (vgaB)
   );

   always #5 clk = ~clk;

   // Drives both resets and both enables in one place.
   task automatic applyStimulus(input logic resetA, input logic resetB, input logic enableA, input logic enableB);
      rstA        = resetA;
      rstB        = resetB;
      vgaA.enable = enableA;
      vgaB.enable = enableB;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Safety net against a stuck run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      repeat (3) @(negedge clk);

      // Reset values on the full-size instance.
      checkOutput("rst pixel_x",     32'(vgaA.pixel_x),     32'd0);
      checkOutput("rst pixel_y",     32'(vgaA.pixel_y),     32'd0);
      checkOutput("rst frame_count", 32'(vgaA.frame_count), 32'd0);
      checkOutput("rst pixel_tick",  32'(vgaA.pixel_tick),  32'd0);
      checkOutput("rst frame_start", 32'(vgaA.frame_start), 32'd0);
      checkOutput("rst hsync",       32'(vgaA.hsync),       32'd1);
      checkOutput("rst vsync",       32'(vgaA.vsync),       32'd1);
      checkOutput("rst video_on",    32'(vgaA.video_on),    32'd1);

      // Release reset; tick must be high going into edges 4, 8, 12 and x steps at those edges.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         checkOutput($sformatf("tick after edge %0d", k), 32'(vgaA.pixel_tick), ((k % 4) == 3) ? 32'd1 : 32'd0);
         checkOutput($sformatf("x after edge %0d", k),    32'(vgaA.pixel_x),    32'(k / 4));
      end

      // Sweep the rest of line 0.
      bad = 0; hsLowTicks = 0; firstHsX = -1; firstBlankX = -1;
      for (int i = 0; i < 4000 && vgaA.pixel_y == 11'd0; i++) begin
         px = int'(vgaA.pixel_x);
         if (vgaA.hsync !== ((px >= 656 && px <= 751) ? 1'b0 : 1'b1)) bad++;
         if (vgaA.video_on !== ((px < 640) ? 1'b1 : 1'b0)) bad++;
         if (vgaA.vsync !== 1'b1) bad++;
         if (vgaA.pixel_tick && !vgaA.hsync) hsLowTicks++;
         if (!vgaA.hsync && firstHsX < 0) firstHsX = px;
         if (!vgaA.video_on && firstBlankX < 0) firstBlankX = px;
         @(negedge clk);
      end
      checkOutput("line wrap y",        32'(vgaA.pixel_y), 32'd1);
      checkOutput("line wrap x",        32'(vgaA.pixel_x), 32'd0);
      checkOutput("line decode errors", 32'(bad),          32'd0);
      checkOutput("hsync low ticks",    32'(hsLowTicks),   32'd96);
      checkOutput("hsync first x",      32'(firstHsX),     32'd656);
      checkOutput("video_on fall x",    32'(firstBlankX),  32'd640);

      // Freeze at x=300 on line 1 while the strobe is high.
      for (int i = 0; i < 2000 && !(vgaA.pixel_x == 11'd300 && vgaA.pixel_tick); i++) @(negedge clk);
      checkOutput("reach x300 tick", 32'(vgaA.pixel_x == 11'd300 && vgaA.pixel_tick), 32'd1);
      hsSnap = vgaA.hsync; vsSnap = vgaA.vsync; voSnap = vgaA.video_on; fcSnap = vgaA.frame_count;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      #1;
      checkOutput("tick suppressed", 32'(vgaA.pixel_tick), 32'd0);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (vgaA.pixel_x !== 11'd300 || vgaA.pixel_y !== 11'd1 || vgaA.pixel_tick !== 1'b0 ||
             vgaA.frame_start !== 1'b0 || vgaA.hsync !== hsSnap || vgaA.vsync !== vsSnap ||
             vgaA.video_on !== voSnap || vgaA.frame_count !== fcSnap) bad++;
      end
      checkOutput("hold errors", 32'(bad), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      #1;
      checkOutput("tick on resume", 32'(vgaA.pixel_tick), 32'd1);
      @(negedge clk);
      checkOutput("x after resume", 32'(vgaA.pixel_x), 32'd301);
      checkOutput("y after resume", 32'(vgaA.pixel_y), 32'd1);

      // Asynchronous reset in the middle of the horizontal sync pulse.
      for (int i = 0; i < 2000 && vgaA.pixel_x != 11'd700; i++) @(negedge clk);
      checkOutput("reach x700",     32'(vgaA.pixel_x), 32'd700);
      checkOutput("hsync at x700",  32'(vgaA.hsync),   32'd0);
      #2;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      #1;
      checkOutput("async pixel_x",     32'(vgaA.pixel_x),     32'd0);
      checkOutput("async pixel_y",     32'(vgaA.pixel_y),     32'd0);
      checkOutput("async hsync",       32'(vgaA.hsync),       32'd1);
      checkOutput("async vsync",       32'(vgaA.vsync),       32'd1);
      checkOutput("async video_on",    32'(vgaA.video_on),    32'd1);
      checkOutput("async pixel_tick",  32'(vgaA.pixel_tick),  32'd0);
      checkOutput("async frame_count", 32'(vgaA.frame_count), 32'd0);

      // Whole frame on the small raster: 15 x 12 = 180 ticks, hsync 10..12, vsync lines 8..9.
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      bad = 0; ticks = 0; vsLowTicks = 0; starts = 0;
      for (int i = 0; i < 600 && vgaB.frame_count == '0; i++) begin
         px = int'(vgaB.pixel_x);
         py = int'(vgaB.pixel_y);
         if (vgaB.hsync !== ((px >= 10 && px <= 12) ? 1'b0 : 1'b1)) bad++;
         if (vgaB.vsync !== ((py >= 8 && py <= 9) ? 1'b0 : 1'b1)) bad++;
         if (vgaB.video_on !== ((px < 8 && py < 6) ? 1'b1 : 1'b0)) bad++;
         if (vgaB.pixel_tick) begin
            ticks++;
            if (!vgaB.vsync) vsLowTicks++;
         end
         if (vgaB.frame_start) starts++;
         @(negedge clk);
      end
      checkOutput("frame count 1",        32'(vgaB.frame_count), 32'd1);
      checkOutput("ticks per frame",      32'(ticks),            32'd180);
      checkOutput("vsync low ticks",      32'(vsLowTicks),       32'd30);
      checkOutput("frame decode errors",  32'(bad),              32'd0);
      checkOutput("no early frame_start", 32'(starts),           32'd0);
      checkOutput("frame_start at wrap",  32'(vgaB.frame_start), 32'd1);
      checkOutput("wrap x",               32'(vgaB.pixel_x),     32'd0);
      checkOutput("wrap y",               32'(vgaB.pixel_y),     32'd0);
      @(negedge clk);
      checkOutput("frame_start one clk",  32'(vgaB.frame_start), 32'd0);

      // Preload the frame counter at its maximum and let the next frame wrap it.
      force dutB.r_frame_count = 28'hFFFFFFF;
      repeat (3) @(negedge clk);
      release dutB.r_frame_count;
      @(negedge clk);
      checkOutput("preload held", 32'(vgaB.frame_count), 32'h0FFFFFFF);
      waitCount = 0;
      while (waitCount < 400 && vgaB.frame_start !== 1'b1) begin
         @(negedge clk);
         waitCount++;
      end
      checkOutput("wrap frame_start", 32'(vgaB.frame_start), 32'd1);
      checkOutput("wrap frame_count", 32'(vgaB.frame_count), 32'd0);
      checkOutput("wrap2 x",          32'(vgaB.pixel_x),     32'd0);
      checkOutput("wrap2 y",          32'(vgaB.pixel_y),     32'd0);
      @(negedge clk);
      checkOutput("wrap count stays", 32'(vgaB.frame_count), 32'd0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
